mem_data_unit: RTL and testbench

- Memory-side load/store sequencer that produces the memory data values (mdr16, mdr8) written back into the register file, and performs stores of register data.
- Bridges the datapath to an 8-bit, ready-handshaked memory bus.
- 16-bit accesses take two byte transfers, little-endian: byte at addr is the low byte, byte at addr+1 is the high byte.
- Sits directly upstream of the register-file write mux.

---
 rtl/mem_data_unit_if.sv | 34 +++
 rtl/mem_data_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_data_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_data_unit_if.sv
// mem_data_unit_if: request/response and byte-wide memory bus bundle for mem_data_unit.
//   start/wr/d8_d16/addr/wdata : datapath access request (sampled with start)
//   mdr16/mdr8                 : load data toward the register-file write mux
//   busy/done/err              : access status; err qualifies done (timeout)
//   mem_*                      : 8-bit ready-handshaked memory bus
// slave  = the sequencer side, master = the datapath/memory side.
interface mem_data_unit_if;
    logic        start;
    logic        wr;
    logic        d8_d16;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [15:0] mdr16;
    logic [7:0]  mdr8;
    logic        busy;
    logic        done;
    logic        err;

    modport slave (
        input  start, wr, d8_d16, addr, wdata, mem_rdata, mem_ready,
        output mem_addr, mem_rd, mem_wr, mem_wdata, mdr16, mdr8, busy, done, err
    );

    modport master (
        output start, wr, d8_d16, addr, wdata, mem_rdata, mem_ready,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, mdr16, mdr8, busy, done, err
    );
endinterface

// File: rtl/mem_data_unit.sv
// mem_data_unit: load/store sequencer between the datapath and an 8-bit memory bus.
// 16-bit accesses are split into two little-endian byte transfers (addr, addr+1).
// Each byte transfer holds its request until mem_ready, or aborts after WAIT_MAX
// idle cycles. Completion is signalled by a one-cycle done (err=1 on timeout).
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_data_unit_if.slave (request, memory bus, mdr16/mdr8, status)
module mem_data_unit #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic           clock,
    input  logic           reset,
    mem_data_unit_if.slave bus
);
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER_LO = 2'd1,
        XFER_HI = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic                d16_q, d16_d;
    logic [15:0]         addr_q, addr_d;
    logic [7:0]          wdata_hi_q, wdata_hi_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                abort_q, abort_d;
    logic [15:0]         mem_addr_q, mem_addr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic [15:0]         mdr16_q, mdr16_d;
    logic [7:0]          mdr8_q, mdr8_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        d16_d       = d16_q;
        addr_d      = addr_q;
        wdata_hi_d  = wdata_hi_q;
        wait_d      = wait_q;
        abort_d     = abort_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_wdata_d = mem_wdata_q;
        mdr16_d     = mdr16_q;
        mdr8_d      = mdr8_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    wr_d        = bus.wr;
                    d16_d       = bus.d8_d16;
                    addr_d      = bus.addr;
                    wdata_hi_d  = bus.wdata[15:8];
                    wait_d      = '0;
                    abort_d     = 1'b0;
                    mem_addr_d  = bus.addr;
                    mem_rd_d    = !bus.wr;
                    mem_wr_d    = bus.wr;
                    mem_wdata_d = bus.wdata[7:0];
                    busy_d      = 1'b1;
                    state_d     = XFER_LO;
                end
            end

            XFER_LO: begin
                if (bus.mem_ready) begin
                    if (!wr_q) begin
                        mdr8_d       = bus.mem_rdata;
                        mdr16_d[7:0] = bus.mem_rdata;
                        if (!d16_q) begin
                            mdr16_d[15:8] = 8'h00;
                        end
                    end
                    if (d16_q) begin
                        // Chain straight into the high byte, request stays up.
                        mem_addr_d  = addr_q + 16'd1;
                        mem_wdata_d = wdata_hi_q;
                        wait_d      = '0;
                        state_d     = XFER_HI;
                    end else begin
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                        state_d  = FIN;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    abort_d  = 1'b1;
                    state_d  = FIN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            XFER_HI: begin
                if (bus.mem_ready) begin
                    if (!wr_q) begin
                        mdr16_d[15:8] = bus.mem_rdata;
                    end
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = FIN;
                end else if (wait_q == WAIT_LAST) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    abort_d  = 1'b1;
                    state_d  = FIN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            FIN: begin
                done_d  = 1'b1;
                err_d   = abort_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            d16_q       <= 1'b0;
            addr_q      <= '0;
            wdata_hi_q  <= '0;
            wait_q      <= '0;
            abort_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            mdr16_q     <= '0;
            mdr8_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            d16_q       <= d16_d;
            addr_q      <= addr_d;
            wdata_hi_q  <= wdata_hi_d;
            wait_q      <= wait_d;
            abort_q     <= abort_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            mdr16_q     <= mdr16_d;
            mdr8_q      <= mdr8_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mdr16     = mdr16_q;
    assign bus.mdr8      = mdr8_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_data_unit.sv
// tb_mem_data_unit: randomized self-checking bench for mem_data_unit.
// A transaction-level model derives, from the access parameters and the wait
// pattern the bench chooses, the expected per-cycle bus/status values, which a
// negedge compare process checks; directed cases pin literal results.
`timescale 1ns/1ps
module tb_mem_data_unit;
    localparam int unsigned WAIT_MAX = 15;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_data_unit_if bus();

    mem_data_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]  mem [0:65535];

    logic        exp_req, exp_rd, exp_wr, exp_busy, exp_done, exp_err;
    logic [15:0] exp_addr, exp_mdr16;
    logic [7:0]  exp_wdata, exp_mdr8;
    bit          chk_en;
    int          n_pass, n_total;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, want, $time);
    endtask

    // Per-cycle compare against the model's expectations.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy",   16'(bus.busy),   16'(exp_busy));
            chk("done",   16'(bus.done),   16'(exp_done));
            chk("err",    16'(bus.err),    16'(exp_err));
            chk("mem_rd", 16'(bus.mem_rd), 16'(exp_rd));
            chk("mem_wr", 16'(bus.mem_wr), 16'(exp_wr));
            chk("rd_wr_exclusive", 16'(bus.mem_rd & bus.mem_wr), 16'd0);
            chk("mdr16",  bus.mdr16,       exp_mdr16);
            chk("mdr8",   16'(bus.mdr8),   16'(exp_mdr8));
            if (exp_req) begin
                chk("mem_addr", bus.mem_addr, exp_addr);
                if (exp_wr) chk("mem_wdata", 16'(bus.mem_wdata), 16'(exp_wdata));
            end
        end
    end

    task automatic set_idle();
        exp_req = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            bus.start     = 1'b0;
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.mem_rdata = 8'($urandom);
            set_idle();
        end
    endtask

    // One access: wl/wh = not-ready cycles before mem_ready for each byte
    // (>= WAIT_MAX means the byte never completes). Returns done latency.
    task automatic run_txn(input bit t_wr, input bit t_d16, input logic [15:0] t_addr,
                           input logic [15:0] t_wdata, input int wl, input int wh,
                           input bit spam, output int lat, output logic err_seen);
        int lo_len, hi_len, fin, idx;
        bit lo_ok, hi_ok, tmo, in_lo, rdy, upd;
        logic [15:0] a, nxt16;
        logic [7:0]  nxt8, b;
        lo_ok  = (wl < int'(WAIT_MAX));
        lo_len = lo_ok ? wl + 1 : int'(WAIT_MAX);
        hi_ok  = (wh < int'(WAIT_MAX));
        hi_len = (t_d16 && lo_ok) ? (hi_ok ? wh + 1 : int'(WAIT_MAX)) : 0;
        tmo    = !lo_ok || (t_d16 && !hi_ok);
        fin    = 1 + lo_len + hi_len;
        lat = -1; err_seen = 1'bx; upd = 1'b0;
        nxt16 = exp_mdr16; nxt8 = exp_mdr8;

        @(posedge clock); #1;
        bus.start = 1'b1; bus.wr = t_wr; bus.d8_d16 = t_d16;
        bus.addr = t_addr; bus.wdata = t_wdata;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
        set_idle();

        for (int k = 1; k <= fin + 1; k++) begin
            @(posedge clock); #1;
            if (bus.done && lat < 0) begin lat = k; err_seen = bus.err; end
            if (upd) begin exp_mdr16 = nxt16; exp_mdr8 = nxt8; upd = 1'b0; end
            bus.start = (spam && k <= fin) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (spam) begin
                bus.wr = 1'($urandom); bus.d8_d16 = 1'($urandom);
                bus.addr = 16'($urandom); bus.wdata = 16'($urandom);
            end
            bus.mem_rdata = 8'($urandom);
            if (k < fin) begin
                in_lo = (k <= lo_len);
                a     = in_lo ? t_addr : t_addr + 16'd1;
                idx   = in_lo ? k - 1 : k - 1 - lo_len;
                rdy   = in_lo ? (lo_ok && idx == wl) : (hi_ok && idx == wh);
                exp_req = 1'b1; exp_rd = !t_wr; exp_wr = t_wr;
                exp_addr = a; exp_wdata = in_lo ? t_wdata[7:0] : t_wdata[15:8];
                exp_busy = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
                bus.mem_ready = rdy;
                if (rdy) begin
                    b = mem[a];
                    if (t_wr) begin
                        mem[bus.mem_addr] = bus.mem_wdata;
                    end else begin
                        bus.mem_rdata = mem[bus.mem_addr];
                        if (in_lo) begin
                            nxt8  = b;
                            nxt16 = t_d16 ? {exp_mdr16[15:8], b} : {8'h00, b};
                        end else begin
                            nxt16 = {b, exp_mdr16[7:0]};
                        end
                        upd = 1'b1;
                    end
                end
            end else if (k == fin) begin
                set_idle();
                exp_busy = 1'b1;
                bus.mem_ready = 1'($urandom_range(0, 1));
            end else begin
                set_idle();
                exp_done = 1'b1; exp_err = tmo;
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 12) return r % 3;
        if (r < 16) return int'($urandom_range(0, 6));
        if (r < 18) return int'(WAIT_MAX) - 1;
        return int'(WAIT_MAX);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic e;
        n_pass = 0; n_total = 0; chk_en = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.wr = 1'b0; bus.d8_d16 = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        exp_mdr16 = '0; exp_mdr8 = '0; exp_addr = '0; exp_wdata = '0;
        set_idle();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12;
        mem[16'h2000] = 8'hAB; mem[16'h4000] = 8'h55;

        #22;
        chk("rst_mdr16", bus.mdr16, 16'h0000);
        chk("rst_mdr8", 16'(bus.mdr8), 16'h0000);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_wdata", 16'(bus.mem_wdata), 16'h0000);
        chk("rst_flags", 16'({bus.mem_rd, bus.mem_wr, bus.busy, bus.done, bus.err}), 16'h0000);

        @(posedge clock); #1;
        reset = 1'b1;
        set_idle();
        chk_en = 1;
        idle(2);

        // 16-bit load, zero wait
        run_txn(1'b0, 1'b1, 16'h1000, 16'h0000, 0, 0, 1'b0, lat, e);
        chk("t1_latency", 16'(lat), 16'd4);
        chk("t1_err", 16'(e), 16'd0);
        chk("t1_mdr16", bus.mdr16, 16'h1234);
        chk("t1_mdr8", 16'(bus.mdr8), 16'h0034);
        idle(1);

        // 8-bit load clears the high byte
        run_txn(1'b0, 1'b0, 16'h2000, 16'h0000, 0, 0, 1'b0, lat, e);
        chk("t2_latency", 16'(lat), 16'd3);
        chk("t2_mdr16", bus.mdr16, 16'h00AB);
        chk("t2_mdr8", 16'(bus.mdr8), 16'h00AB);
        idle(1);

        // 16-bit store across the address wrap, two waits per byte
        run_txn(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 2, 2, 1'b0, lat, e);
        chk("t3_latency", 16'(lat), 16'd8);
        chk("t3_mem_ffff", 16'(mem[16'hFFFF]), 16'h00EF);
        chk("t3_mem_0000", 16'(mem[16'h0000]), 16'h00BE);
        chk("t3_mdr16", bus.mdr16, 16'h00AB);
        idle(2);

        // high-byte timeout keeps the captured low byte
        run_txn(1'b0, 1'b1, 16'h4000, 16'h0000, 0, int'(WAIT_MAX), 1'b0, lat, e);
        chk("t4_latency", 16'(lat), 16'(WAIT_MAX + 3));
        chk("t4_err", 16'(e), 16'd1);
        chk("t4_mdr16", bus.mdr16, 16'h0055);
        idle(1);

        // low-byte timeout on an 8-bit store
        run_txn(1'b1, 1'b0, 16'h5000, 16'h0011, int'(WAIT_MAX), 0, 1'b0, lat, e);
        chk("t5_latency", 16'(lat), 16'(WAIT_MAX + 2));
        chk("t5_err", 16'(e), 16'd1);
        idle(1);

        // start pulses while busy and in FIN are ignored
        run_txn(1'b0, 1'b0, 16'h1001, 16'h0000, 1, 0, 1'b1, lat, e);
        chk("t6_latency", 16'(lat), 16'd4);
        chk("t6_mdr8", 16'(bus.mdr8), 16'h0012);
        idle(3);

        // asynchronous reset in the middle of a high-byte load
        chk_en = 0;
        @(posedge clock); #1;
        bus.start = 1'b1; bus.wr = 1'b0; bus.d8_d16 = 1'b1; bus.addr = 16'h3000;
        bus.mem_ready = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 8'h77;
        @(posedge clock); #1;
        bus.mem_ready = 1'b0;
        chk("pre_rst_mem_rd", 16'(bus.mem_rd), 16'd1);
        chk("pre_rst_mem_addr", bus.mem_addr, 16'h3001);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_flags", 16'({bus.mem_rd, bus.mem_wr, bus.busy, bus.done, bus.err}), 16'h0000);
        chk("mid_rst_mdr16", bus.mdr16, 16'h0000);
        chk("mid_rst_mdr8", 16'(bus.mdr8), 16'h0000);
        chk("mid_rst_mem_addr", bus.mem_addr, 16'h0000);
        @(posedge clock); #1;
        reset = 1'b1;
        exp_mdr16 = '0; exp_mdr8 = '0;
        set_idle();
        chk_en = 1;
        idle(2);
        run_txn(1'b0, 1'b0, 16'h2000, 16'h0000, 0, 0, 1'b0, lat, e);
        chk("t7_latency", 16'(lat), 16'd3);
        chk("t7_err", 16'(e), 16'd0);
        chk("t7_mdr16", bus.mdr16, 16'h00AB);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            idle(int'($urandom_range(0, 2)));
            run_txn(1'($urandom), 1'($urandom), ra, 16'($urandom),
                    pick_wait(), pick_wait(), 1'($urandom_range(0, 3) == 0), lat, e);
        end
        idle(2);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
